mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Initiator side of the data-RAM port: accepts one load/store request at a time from the MEM stage and drives the RAM's ce/we/addr/byte-select/data lines. Sub-word accesses are converted to byte-lane selects. Load data is extracted and sign- or zero-extended. Misaligned accesses are rejected without touching the RAM. A 3-state FSM with valid/ready handshakes on both the request and response sides decouples the pipeline from RAM timing.

## Interface
- ADDR_W, 32, request/RAM address width
- DATA_W, 32, data width (fixed 4 byte lanes)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed_i  in  1  sign-extend load result
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  store data, right-aligned
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  consumer takes response
- resp_rdata_o  out  DATA_W  extended load data; 0 for stores/errors
- resp_err_o  out  1  misaligned or reserved-size request
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  word address, bits [1:0] forced 0
- ram_sel_o  out  4  byte-lane enables; bit3 = data[31:24]
- ram_data_o  out  DATA_W  lane-replicated store data
- ram_data_i  in  DATA_W  RAM read data, combinational from ram_addr_o

## Operation
- Byte order is big-endian:
  - Byte at addr[1:0]=00 → lane 3, sel 1000; 01 → 0100; 10 → 0010; 11 → 0001.
  - Half at 00 → 1100; half at 10 → 0011. Word → 1111.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. size=11 is always an error.
- Store data replication:
  - Byte → {4{wdata[7:0]}}
  - Half → {2{wdata[15:0]}}
  - Word → wdata
- Load extraction: the selected lane(s) are right-aligned into the result. Upper bits are filled with the lane MSB if req_signed_i=1, else 0. req_signed_i is ignored for words.
- FSM:
  - IDLE: req_ready_o=1. On req_valid_i: latch the request and decode. Aligned → ACCESS. Error → RESP with err=1; the RAM is never enabled.
  - ACCESS (exactly 1 cycle): ram_ce_o=1, ram_we_o=req_we, sel/addr/data driven from latched values. Loads capture the extended ram_data_i at the closing edge. Stores commit in the RAM at the same edge. → RESP.
  - RESP: resp_valid_o=1. Outputs are held stable until resp_ready_i=1, then → IDLE.
- Outside ACCESS: ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o and ram_data_o are all 0.
- All outputs are decoded from registered state and latched fields; there are no combinational paths from req_* or resp_ready_i to outputs.

## Timing
- Reset (rst=0 at an edge):
  - State → IDLE.
  - All outputs → 0 while rst=0, including req_ready_o.
  - req_ready_o=1 in the first cycle after rst returns to 1.
- Request accepted at edge N → ACCESS during cycle N+1 → resp_valid_o high from N+2.
- Best-case throughput: one request per 3 cycles. An error response also arrives at N+1 (RESP directly).
- A response is held indefinitely under resp_ready_i=0. No new request is accepted until the RESP→IDLE transition.
- Reset during ACCESS of a store: the write still commits at that edge, because the RAM samples we at the same edge. The response is discarded.
- Reset during RESP: the response is dropped and resp_valid_o=0 after the edge.
- req_valid_i while req_ready_o=0 is ignored; the requester must hold the request.

## Test plan
- Word store addr=0x10, wdata=0xDEADBEEF:
  - ACCESS cycle shows ce=1, we=1, sel=1111, addr=0x10, data=0xDEADBEEF.
  - Then resp_valid=1, err=0, rdata=0.
- Byte store addr=0x13, wdata=0x000000A5 → sel=0001, ram_data=0xA5A5A5A5. A following word load at 0x10 returns only the low byte changed (0xDEADBEA5).
- Sign-extended loads, RAM word 0x80FF7F01:
  - Signed byte at 0x00 → 0xFFFFFF80.
  - Unsigned byte at 0x00 → 0x00000080.
  - Signed half at 0x02 → 0x00007F01.
  - Signed half at 0x00 → 0xFFFF80FF.
- Misaligned half at 0x21 and word at 0x22:
  - resp_err=1 one cycle after acceptance.
  - ram_ce_o stays 0 throughout.
  - RAM contents unchanged.
- Backpressure: hold resp_ready_i=0 for 5 cycles → resp_valid, rdata and err stay constant; req_ready_o=0; ram_ce_o=0.
- Reset mid-operation:
  - rst=0 during ACCESS of a word store 0x12345678 → RAM at that address reads 0x12345678 afterwards, no response is issued, and req_ready_o returns 1 in the first cycle after reset releases.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for a data RAM with big-endian byte lanes
//   clk, rst (sync, active-low)
//   req_*_i / req_ready_o   : request handshake, store data right-aligned
//   resp_*_o / resp_ready_i : response handshake, extended load data or error
//   ram_*_o / ram_data_i    : RAM port, enabled only during the single ACCESS cycle
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic live_q;
  logic we_q, we_d, signed_q, signed_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic req_err;
  logic [3:0] req_sel;
  logic [DATA_W-1:0] req_rep, load_ext;
  logic [4:0] shamt;
  logic [15:0] lane;
  logic acc;
  always_comb begin
    req_err = (req_size_i == 2'b11) || (req_size_i == 2'b01 && req_addr_i[0]) ||
              (req_size_i == 2'b10 && |req_addr_i[1:0]);
    req_sel = req_size_i == 2'b00 ? 4'b1000 >> req_addr_i[1:0] :
              req_size_i == 2'b01 ? (req_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    req_rep = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
              req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    // lane 3 holds the lowest byte address, so the shift right-aligns the addressed lane(s)
    shamt = size_q == 2'b00 ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
    lane = 16'(ram_data_i >> shamt);
    load_ext = size_q == 2'b00 ? {{24{signed_q & lane[7]}}, lane[7:0]} :
               size_q == 2'b01 ? {{16{signed_q & lane[15]}}, lane} : ram_data_i;
  end
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    size_d = size_q;
    signed_d = signed_q;
    addr_d = addr_q;
    sel_d = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    unique case (state_q)
      IDLE:
        if (req_valid_i && live_q) begin
          we_d = req_we_i;
          size_d = req_size_i;
          signed_d = req_signed_i;
          addr_d = req_addr_i;
          sel_d = req_sel;
          wdata_d = req_rep;
          rdata_d = '0;
          err_d = req_err;
          state_d = req_err ? RESP : ACCESS;
        end
      ACCESS: begin
        rdata_d = we_q ? '0 : load_ext;
        state_d = RESP;
      end
      RESP: state_d = resp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= '0;
      signed_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      we_q <= we_d;
      size_q <= size_d;
      signed_q <= signed_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign acc = state_q == ACCESS;
  // live_q keeps ready low through the reset cycles even though the state is already IDLE
  assign req_ready_o = live_q && state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o = resp_valid_o & err_q;
  assign ram_ce_o = acc;
  assign ram_we_o = acc & we_q;
  assign ram_sel_o = acc ? sel_q : '0;
  assign ram_addr_o = acc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign ram_data_o = acc ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized check of mem_access_ctrl against a byte-addressed reference memory
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst, init;
  logic req_valid_i, req_ready_o, req_we_i, req_signed_i;
  logic [1:0] req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0] ram_sel_o;
  logic [31:0] ram [0:63];
  logic [7:0] rmem [0:255];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got;
  always #5 clk = ~clk;
  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .ram_ce_o(ram_ce_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );
  function automatic logic [31:0] seed_word(int i);
    return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A1234;
  endfunction
  assign ram_data_i = ram[ram_addr_o[7:2]];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) ram[i] <= seed_word(i);
    end else if (ram_ce_o && ram_we_o) begin
      for (int l = 0; l < 4; l++)
        if (ram_sel_o[l]) ram[ram_addr_o[7:2]][8*l +: 8] <= ram_data_o[8*l +: 8];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready();
    int t = 0;
    while (!req_ready_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_ready_wait", {31'd0, req_ready_o}, 32'd1);
  endtask
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, output logic [31:0] res);
    int n;
    logic err;
    logic [3:0] esel;
    logic [31:0] erd, rep;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    err = sz == 2'd3 || (a % n) != 0;
    esel = '0;
    erd = '0;
    if (!err) begin
      for (int b = 0; b < n; b++) esel[3 - ((a + b) % 4)] = 1'b1;
      if (we) for (int b = 0; b < n; b++) rmem[a + b] = 8'(wd >> (8 * (n - 1 - b)));
      else begin
        for (int b = 0; b < n; b++) erd = (erd << 8) | 32'(rmem[a + b]);
        if (sg && n < 4 && erd[8*n-1]) erd = erd | (~32'd0 << (8 * n));
      end
    end
    rep = n == 1 ? {4{wd[7:0]}} : n == 2 ? {2{wd[15:0]}} : wd;
    wait_ready();
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_signed_i = sg;
    req_addr_i = a; req_wdata_i = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("ready_busy", {31'd0, req_ready_o}, 32'd0);
    if (!err) begin
      check("acc_ce", {31'd0, ram_ce_o}, 32'd1);
      check("acc_we", {31'd0, ram_we_o}, {31'd0, we});
      check("acc_sel", {28'd0, ram_sel_o}, {28'd0, esel});
      check("acc_addr", ram_addr_o, a & ~32'd3);
      if (we) check("acc_data", ram_data_o, rep);
      check("acc_no_resp", {31'd0, resp_valid_o}, 32'd0);
      @(posedge clk); #1;
    end else check("err_no_ce", {31'd0, ram_ce_o}, 32'd0);
    check("resp_valid", {31'd0, resp_valid_o}, 32'd1);
    check("resp_err", {31'd0, resp_err_o}, {31'd0, err});
    check("resp_rdata", resp_rdata_o, erd);
    res = resp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      req_valid_i = 1'($urandom % 2);
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      check("hold_rdata", resp_rdata_o, erd);
      check("hold_err", {31'd0, resp_err_o}, {31'd0, err});
      check("hold_ready", {31'd0, req_ready_o}, 32'd0);
      check("hold_ce", {31'd0, ram_ce_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check("done_valid", {31'd0, resp_valid_o}, 32'd0);
    check("done_ready", {31'd0, req_ready_o}, 32'd1);
  endtask
  initial begin
    rst = 1'b0; init = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = '0; req_signed_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) rmem[i] = 8'(seed_word(i / 4) >> (8 * (3 - i % 4)));
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    check("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_ce", {31'd0, ram_ce_o}, 32'd0);
    check("rst_sel", {28'd0, ram_sel_o}, 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, req_ready_o}, 32'd1);
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    xact(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, got);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
    check("ld_word_lit", got, 32'hDEADBEA5);
    xact(1'b1, 2'd2, 1'b0, 32'h00, 32'h80FF7F01, 0, got);
    xact(1'b0, 2'd0, 1'b1, 32'h00, 32'h0, 0, got);
    check("lb_signed_lit", got, 32'hFFFFFF80);
    xact(1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 0, got);
    check("lb_unsigned_lit", got, 32'h00000080);
    xact(1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 0, got);
    check("lh_signed2_lit", got, 32'h00007F01);
    xact(1'b0, 2'd1, 1'b1, 32'h00, 32'h0, 0, got);
    check("lh_signed0_lit", got, 32'hFFFF80FF);
    xact(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1, got);
    xact(1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 0, got);
    check("misaligned_untouched", ram[8], {rmem[32], rmem[33], rmem[34], rmem[35]});
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got);
    wait_ready();
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_signed_i = 1'b0;
    req_addr_i = 32'h30; req_wdata_i = 32'h12345678;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst_acc_ce", {31'd0, ram_ce_o}, 32'd1);
    rst = 1'b0;
    {rmem[48], rmem[49], rmem[50], rmem[51]} = 32'h12345678;
    @(posedge clk); #1;
    check("rst_acc_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_acc_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_acc_commit", ram[12], 32'h12345678);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_acc_release", {31'd0, req_ready_o}, 32'd1);
    check("rst_acc_noresp", {31'd0, resp_valid_o}, 32'd0);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h30;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_pre", {31'd0, resp_valid_o}, 32'd1);
    check("rst_resp_data", resp_rdata_o, 32'h12345678);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_drop", {31'd0, resp_valid_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_resp_release", {31'd0, req_ready_o}, 32'd1);
    for (int k = 0; k < 300; k++)
      xact(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), 32'($urandom_range(0, 255)),
           $urandom, $urandom_range(0, 3), got);
    for (int i = 0; i < 64; i++)
      check("final_ram", ram[i], {rmem[4*i], rmem[4*i+1], rmem[4*i+2], rmem[4*i+3]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
